// File: rtl/ldpc_ber_tester_pkg.sv
// -----------------------------------------------------------------------------
// ldpc_ber_tester_pkg
// Shared definitions for the LDPC BER tester decoder stub: FSM state encoding,
// control/status word field positions, DOUT packing factor and a helper that
// turns the 16-bit beat-count field into the real block length.
// -----------------------------------------------------------------------------
package ldpc_ber_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_EMIT,
      ST_STATUS
   } state_e;

   // Control word fields
   localparam int CTRL_N_LSB    = 0;
   localparam int CTRL_N_W      = 16;
   localparam int CTRL_ID_LSB   = 16;
   localparam int CTRL_ID_W     = 8;

   // Status word fields
   localparam int STAT_ITER_LSB = 0;
   localparam int STAT_ID_LSB   = 8;
   localparam int STAT_ERR_BIT  = 16;

   // DIN beats packed into one DOUT beat
   localparam int BEATS_PER_DOUT = 8;
   localparam int AXIS_DATA_W    = 128;

   // A zero beat-count field encodes the maximum block of 65536 beats.
   function automatic logic [16:0] decode_beat_count(input logic [15:0] field);
      return (field == 16'd0) ? 17'h1_0000 : {1'b0, field};
   endfunction

endpackage

// File: rtl/ldpc_ber_tester_dec_stub.sv
// -----------------------------------------------------------------------------
// ldpc_ber_tester_dec_stub
// Stand-in for the LDPC decoder core. Takes one control word per block, consumes
// N DIN beats of LLRs, returns the LLR sign bits packed 8 DIN beats per DOUT
// beat, then one STATUS word carrying the block ID and a tlast-mismatch flag.
//
// Ports
//   clk, reset                 datapath clock, synchronous active-high reset
//   s_axis_ctrl_*              control word: [15:0] beat count, [23:16] ID
//   s_axis_din_*               128-bit LLR beats, tlast only checked
//   m_axis_dout_*              packed hard decisions, tlast on final beat
//   m_axis_status_*            [7:0] ITER_COUNT, [15:8] ID, [16] tlast error
//   blocks_done                completed STATUS handshakes (wraps)
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module ldpc_ber_tester_dec_stub
   import ldpc_ber_tester_pkg::*;
#(
   parameter logic [7:0] ITER_COUNT = 8'd1,
   parameter int         LLR_W      = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  s_axis_ctrl_tdata,
   input  logic         s_axis_ctrl_tvalid,
   output logic         s_axis_ctrl_tready,
   input  logic [127:0] s_axis_din_tdata,
   input  logic         s_axis_din_tvalid,
   output logic         s_axis_din_tready,
   input  logic         s_axis_din_tlast,
   output logic [127:0] m_axis_dout_tdata,
   output logic         m_axis_dout_tvalid,
   input  logic         m_axis_dout_tready,
   output logic         m_axis_dout_tlast,
   output logic [31:0]  m_axis_status_tdata,
   output logic         m_axis_status_tvalid,
   input  logic         m_axis_status_tready,
   output logic [31:0]  blocks_done,
   output logic         busy
);

   localparam int LLRS = AXIS_DATA_W / LLR_W;

   state_e      state_q, state_d;
   logic [16:0] n_q, n_d;
   logic [7:0]  id_q, id_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [127:0] pack_q, pack_d;
   logic [16:0] beat_q, beat_d;
   logic [2:0]  slot_q, slot_d;
   logic [31:0] blocks_done_q, blocks_done_d;
   logic        ctrl_rdy_q, ctrl_rdy_d;

   logic [LLRS-1:0] din_signs;
   logic            last_beat;
   logic            unused_inputs;

   // Only the sign bit of each LLR and the low 24 control bits matter.
   assign unused_inputs = ^{s_axis_ctrl_tdata[31:24], s_axis_din_tdata};

   always_comb begin
      din_signs = '0;
      for (int i = 0; i < LLRS; i++) begin
         din_signs[i] = s_axis_din_tdata[LLR_W*i + LLR_W-1];
      end
   end

   // The beat being offered now is number beat_q+1 (1-based).
   assign last_beat = ((beat_q + 17'd1) == n_q);

   // NOTE: every variable gets its hold value first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      id_d          = id_q;
      err_d         = err_q;
      done_d        = done_q;
      pack_d        = pack_q;
      beat_d        = beat_q;
      slot_d        = slot_q;
      blocks_done_d = blocks_done_q;

      unique case (state_q)
         ST_IDLE: begin
            if (s_axis_ctrl_tvalid && ctrl_rdy_q) begin
               n_d     = decode_beat_count(s_axis_ctrl_tdata[CTRL_N_LSB +: CTRL_N_W]);
               id_d    = s_axis_ctrl_tdata[CTRL_ID_LSB +: CTRL_ID_W];
               err_d   = 1'b0;
               done_d  = 1'b0;
               pack_d  = '0;
               beat_d  = '0;
               slot_d  = '0;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (s_axis_din_tvalid) begin
               for (int s = 0; s < BEATS_PER_DOUT; s++) begin
                  if (slot_q == 3'(s)) pack_d[s*LLRS +: LLRS] = din_signs;
               end
               beat_d = beat_q + 17'd1;
               slot_d = slot_q + 3'd1;   // wraps to 0 after slot 7
               if (s_axis_din_tlast != last_beat) err_d = 1'b1;
               if (last_beat) done_d = 1'b1;
               if (last_beat || slot_q == 3'd7) state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (m_axis_dout_tready) begin
               if (done_q) begin
                  state_d = ST_STATUS;
               end else begin
                  pack_d  = '0;   // partial final group must read as zeros
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_STATUS: begin
            if (m_axis_status_tready) begin
               blocks_done_d = blocks_done_q + 32'd1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered so ready stays low while reset is held and rises one cycle later.
      ctrl_rdy_d = (state_d == ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         n_q           <= '0;
         id_q          <= '0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         // NOTE: the pack register is reset because it drives dout_tdata directly and must read zero out of reset.
         pack_q        <= '0;
         beat_q        <= '0;
         slot_q        <= '0;
         blocks_done_q <= '0;
         ctrl_rdy_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         id_q          <= id_d;
         err_q         <= err_d;
         done_q        <= done_d;
         pack_q        <= pack_d;
         beat_q        <= beat_d;
         slot_q        <= slot_d;
         blocks_done_q <= blocks_done_d;
         ctrl_rdy_q    <= ctrl_rdy_d;
      end
   end

   assign s_axis_ctrl_tready   = ctrl_rdy_q;
   assign s_axis_din_tready    = (state_q == ST_COLLECT);
   assign m_axis_dout_tvalid   = (state_q == ST_EMIT);
   assign m_axis_dout_tdata    = pack_q;
   assign m_axis_dout_tlast    = (state_q == ST_EMIT) && done_q;
   assign m_axis_status_tvalid = (state_q == ST_STATUS);

   always_comb begin
      m_axis_status_tdata = '0;
      if (state_q == ST_STATUS) begin
         m_axis_status_tdata[STAT_ITER_LSB +: 8] = ITER_COUNT;
         m_axis_status_tdata[STAT_ID_LSB +: 8]   = id_q;
         m_axis_status_tdata[STAT_ERR_BIT]       = err_q;
      end
   end

   assign blocks_done = blocks_done_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ldpc_ber_tester_dec_stub.sv
// -----------------------------------------------------------------------------
// tb_ldpc_ber_tester_dec_stub
// Directed bench for the LDPC decoder stub: reset values, full and partial
// groups, multi-beat blocks, tlast mismatch, long backpressure and a reset
// in the middle of a block. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_ldpc_ber_tester_dec_stub;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  s_axis_ctrl_tdata;
   logic         s_axis_ctrl_tvalid;
   logic         s_axis_ctrl_tready;
   logic [127:0] s_axis_din_tdata;
   logic         s_axis_din_tvalid;
   logic         s_axis_din_tready;
   logic         s_axis_din_tlast;
   logic [127:0] m_axis_dout_tdata;
   logic         m_axis_dout_tvalid;
   logic         m_axis_dout_tready;
   logic         m_axis_dout_tlast;
   logic [31:0]  m_axis_status_tdata;
   logic         m_axis_status_tvalid;
   logic         m_axis_status_tready;
   logic [31:0]  blocks_done;
   logic         busy;

   int passed = 0;
   int total  = 0;

   localparam logic [127:0] ALL_NEG  = {16{8'h80}};
   localparam logic [127:0] ALL_POS  = {16{8'h00}};
   localparam logic [127:0] ALT_LANE = {8{16'h807F}};
   localparam logic [127:0] ONE_LANE = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

   always #5 clk = ~clk;

   ldpc_ber_tester_dec_stub dut (
      .clk                  (clk),
      .reset                (reset),
      .s_axis_ctrl_tdata    (s_axis_ctrl_tdata),
      .s_axis_ctrl_tvalid   (s_axis_ctrl_tvalid),
      .s_axis_ctrl_tready   (s_axis_ctrl_tready),
      .s_axis_din_tdata     (s_axis_din_tdata),
      .s_axis_din_tvalid    (s_axis_din_tvalid),
      .s_axis_din_tready    (s_axis_din_tready),
      .s_axis_din_tlast     (s_axis_din_tlast),
      .m_axis_dout_tdata    (m_axis_dout_tdata),
      .m_axis_dout_tvalid   (m_axis_dout_tvalid),
      .m_axis_dout_tready   (m_axis_dout_tready),
      .m_axis_dout_tlast    (m_axis_dout_tlast),
      .m_axis_status_tdata  (m_axis_status_tdata),
      .m_axis_status_tvalid (m_axis_status_tvalid),
      .m_axis_status_tready (m_axis_status_tready),
      .blocks_done          (blocks_done),
      .busy                 (busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge; all driving and sampling happens here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ctrl(input logic [15:0] n, input logic [7:0] id);
      int t = 0;
      s_axis_ctrl_tdata  = {8'hC3, id, n};
      s_axis_ctrl_tvalid = 1'b1;
      while (!s_axis_ctrl_tready && t < 100) begin
         step();
         t++;
      end
      check("ctrl_ready_wait", s_axis_ctrl_tready, 1'b1);
      step();
      s_axis_ctrl_tvalid = 1'b0;
      s_axis_ctrl_tdata  = 32'hDEAD_BEEF;
   endtask

   task automatic send_beat(input logic [127:0] data, input logic last);
      int t = 0;
      s_axis_din_tdata  = data;
      s_axis_din_tlast  = last;
      s_axis_din_tvalid = 1'b1;
      while (!s_axis_din_tready && t < 100) begin
         step();
         t++;
      end
      check("din_ready_wait", s_axis_din_tready, 1'b1);
      step();
      s_axis_din_tvalid = 1'b0;
      s_axis_din_tdata  = {8{16'h1234}};
      s_axis_din_tlast  = 1'b1;
   endtask

   task automatic recv_dout(input string tag, input logic [127:0] exp_data, input logic exp_last);
      int t = 0;
      while (!m_axis_dout_tvalid && t < 100) begin
         step();
         t++;
      end
      check({tag, "_valid"}, m_axis_dout_tvalid, 1'b1);
      check({tag, "_data"}, m_axis_dout_tdata, exp_data);
      check({tag, "_last"}, m_axis_dout_tlast, exp_last);
      m_axis_dout_tready = 1'b1;
      step();
      m_axis_dout_tready = 1'b0;
   endtask

   task automatic recv_status(input string tag, input logic [31:0] exp_word);
      int t = 0;
      while (!m_axis_status_tvalid && t < 100) begin
         step();
         t++;
      end
      check({tag, "_valid"}, m_axis_status_tvalid, 1'b1);
      check({tag, "_data"}, m_axis_status_tdata, exp_word);
      m_axis_status_tready = 1'b1;
      step();
      m_axis_status_tready = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset                = 1'b1;
      s_axis_ctrl_tdata    = '0;
      s_axis_ctrl_tvalid   = 1'b0;
      s_axis_din_tdata     = '0;
      s_axis_din_tvalid    = 1'b0;
      s_axis_din_tlast     = 1'b0;
      m_axis_dout_tready   = 1'b0;
      m_axis_status_tready = 1'b0;

      // ---- Reset values ----
      step(); step(); step();
      check("rst_ctrl_tready", s_axis_ctrl_tready, 1'b0);
      check("rst_din_tready", s_axis_din_tready, 1'b0);
      check("rst_dout_tvalid", m_axis_dout_tvalid, 1'b0);
      check("rst_dout_tdata", m_axis_dout_tdata, 128'd0);
      check("rst_dout_tlast", m_axis_dout_tlast, 1'b0);
      check("rst_status_tvalid", m_axis_status_tvalid, 1'b0);
      check("rst_status_tdata", m_axis_status_tdata, 32'd0);
      check("rst_blocks_done", blocks_done, 32'd0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      check("ctrl_ready_still_low", s_axis_ctrl_tready, 1'b0);
      step();
      check("ctrl_ready_rises", s_axis_ctrl_tready, 1'b1);

      // ---- N=8, all negative LLRs ----
      do_ctrl(16'd8, 8'h5A);
      check("b1_din_ready_next", s_axis_din_tready, 1'b1);
      check("b1_busy", busy, 1'b1);
      for (int k = 1; k <= 8; k++) send_beat(ALL_NEG, k == 8);
      check("b1_dout_valid_next", m_axis_dout_tvalid, 1'b1);
      check("b1_din_ready_emit", s_axis_din_tready, 1'b0);
      recv_dout("b1_dout", {128{1'b1}}, 1'b1);
      check("b1_status_valid_next", m_axis_status_tvalid, 1'b1);
      recv_status("b1_status", 32'h0000_5A01);
      check("b1_ctrl_ready_next", s_axis_ctrl_tready, 1'b1);
      check("b1_blocks_done", blocks_done, 32'd1);
      check("b1_busy_idle", busy, 1'b0);

      // ---- N=3, alternating 0x7F/0x80 lanes ----
      do_ctrl(16'd3, 8'h11);
      for (int k = 1; k <= 3; k++) send_beat(ALT_LANE, k == 3);
      recv_dout("b2_dout", {80'd0, 48'hAAAA_AAAA_AAAA}, 1'b1);
      recv_status("b2_status", 32'h0000_1101);
      check("b2_blocks_done", blocks_done, 32'd2);

      // ---- N=20, three DOUT beats ----
      do_ctrl(16'd20, 8'h20);
      for (int k = 1; k <= 20; k++) begin
         send_beat(ALL_NEG, k == 20);
         if (k == 8)  recv_dout("b3_dout1", {128{1'b1}}, 1'b0);
         if (k == 16) recv_dout("b3_dout2", {128{1'b1}}, 1'b0);
      end
      recv_dout("b3_dout3", {64'd0, {64{1'b1}}}, 1'b1);
      recv_status("b3_status", 32'h0000_2001);
      check("b3_blocks_done", blocks_done, 32'd3);

      // ---- N=4, tlast early on beat 2 and missing on beat 4 ----
      do_ctrl(16'd4, 8'h44);
      send_beat(ALL_NEG, 1'b0);
      send_beat(ALL_NEG, 1'b1);
      check("b4_no_truncate", s_axis_din_tready, 1'b1);
      send_beat(ALL_NEG, 1'b0);
      send_beat(ALL_NEG, 1'b0);
      check("b4_emit_after_4", m_axis_dout_tvalid, 1'b1);
      recv_dout("b4_dout", {64'd0, {64{1'b1}}}, 1'b1);
      recv_status("b4_status", 32'h0001_4401);
      check("b4_blocks_done", blocks_done, 32'd4);

      // ---- Backpressure on DOUT and STATUS ----
      do_ctrl(16'd1, 8'h77);
      send_beat(ONE_LANE, 1'b1);
      s_axis_din_tvalid = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (m_axis_dout_tvalid !== 1'b1) bad++;
         if (m_axis_dout_tdata !== {112'd0, 16'h8000}) bad++;
         if (m_axis_dout_tlast !== 1'b1) bad++;
         if (s_axis_din_tready !== 1'b0) bad++;
         if (m_axis_status_tvalid !== 1'b0) bad++;
      end
      s_axis_din_tvalid = 1'b0;
      check("bp_dout_stable_cycles", bad, 0);
      recv_dout("bp_dout", {112'd0, 16'h8000}, 1'b1);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (m_axis_status_tvalid !== 1'b1) bad++;
         if (m_axis_status_tdata !== 32'h0000_7701) bad++;
         if (blocks_done !== 32'd4) bad++;
      end
      check("bp_status_stable_cycles", bad, 0);
      recv_status("bp_status", 32'h0000_7701);
      m_axis_status_tready = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (m_axis_status_tvalid !== 1'b0) bad++;
      end
      m_axis_status_tready = 1'b0;
      check("bp_no_extra_status", bad, 0);
      check("bp_blocks_done", blocks_done, 32'd5);

      // ---- Reset during COLLECT, beat 5 of 8 ----
      do_ctrl(16'd8, 8'h99);
      for (int k = 1; k <= 4; k++) send_beat(ALL_NEG, 1'b0);
      s_axis_din_tdata  = ALL_NEG;
      s_axis_din_tlast  = 1'b0;
      s_axis_din_tvalid = 1'b1;
      reset = 1'b1;
      step();
      s_axis_din_tvalid = 1'b0;
      check("mr_busy", busy, 1'b0);
      check("mr_din_ready", s_axis_din_tready, 1'b0);
      check("mr_dout_valid", m_axis_dout_tvalid, 1'b0);
      check("mr_status_valid", m_axis_status_tvalid, 1'b0);
      check("mr_ctrl_ready", s_axis_ctrl_tready, 1'b0);
      reset = 1'b0;
      m_axis_dout_tready   = 1'b1;
      m_axis_status_tready = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (m_axis_dout_tvalid !== 1'b0) bad++;
         if (m_axis_status_tvalid !== 1'b0) bad++;
      end
      m_axis_dout_tready   = 1'b0;
      m_axis_status_tready = 1'b0;
      check("mr_no_output", bad, 0);
      check("mr_ctrl_ready_back", s_axis_ctrl_tready, 1'b1);
      do_ctrl(16'd2, 8'hB2);
      send_beat(ALL_NEG, 1'b0);
      send_beat(ALL_POS, 1'b1);
      recv_dout("mr_dout", {112'd0, 16'hFFFF}, 1'b1);
      recv_status("mr_status", 32'h0000_B201);
      check("mr_blocks_done", blocks_done, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ldpc_ber_tester_dec_stub.md
# ldpc_ber_tester_dec_stub

Decoder-side responder for the LDPC BER tester datapath. It accepts the control word and DIN LLR stream that the tester issues, and returns hard-decision DOUT beats and one STATUS word per block. It stands in for the LDPC decoder core in closed-loop simulation and hardware self-test.

## Interface

- ITER_COUNT, 8'd1: constant reported in the STATUS iteration field.
- LLR_W, 8: LLR width; 128/LLR_W LLRs per DIN beat (16 at default).
- clk  in  1  datapath clock
- reset  in  1  synchronous, active-high
- s_axis_ctrl_tdata  in  32  block control word
- s_axis_ctrl_tvalid  in  1  control valid
- s_axis_ctrl_tready  out  1  control ready
- s_axis_din_tdata  in  128  LLRs, LLR i at bits [LLR_W*i+LLR_W-1 : LLR_W*i]
- s_axis_din_tvalid  in  1
- s_axis_din_tready  out  1
- s_axis_din_tlast  in  1  block end marker, checked only
- m_axis_dout_tdata  out  128  packed hard decisions
- m_axis_dout_tvalid  out  1
- m_axis_dout_tready  in  1
- m_axis_dout_tlast  out  1  final DOUT beat of block
- m_axis_status_tdata  out  32  block status
- m_axis_status_tvalid  out  1
- m_axis_status_tready  in  1
- blocks_done  out  32  count of completed STATUS handshakes, wraps
- busy  out  1  high in every state except IDLE

## Operation

- Control word: [15:0] DIN beat count N (0 means 65536); [23:16] block ID; [31:24] ignored.
- Hard decision: bit = MSB (sign) of each LLR. A beat produces 16 bits (at LLR_W=8).
- Packing: DIN beat k of a group of 8 occupies DOUT bits [16k+15:16k], LSB first. A partial final group zero-fills the unused bits.
- DOUT beat count = ceil(N/8). tlast is set on the last DOUT beat only.
- tlast check: the error flag is set if din_tlast=1 on any beat other than beat N, or din_tlast=0 on beat N. The beat count always governs block length; tlast never truncates or extends a block.
- Status word: [7:0] ITER_COUNT; [15:8] block ID; [16] tlast error flag; [31:17] zero.
- FSM:
  - IDLE: ctrl_tready=1. On the ctrl handshake, latch N and ID, clear the error flag, clear the pack register, then go to COLLECT.
  - COLLECT: din_tready=1. On each beat, write the sign bits into the slot and increment the beat and slot counters. After the 8th slot or beat N, go to EMIT.
  - EMIT: dout_tvalid=1, with data and tlast held stable. On handshake, go to STATUS if the block is done; otherwise clear the pack register and go to COLLECT.
  - STATUS: status_tvalid=1, data held. On handshake, increment blocks_done and go to IDLE.
- Counters: 17-bit beat counter (handles 65536); 3-bit slot index.
- ctrl_tdata and din_tdata are ignored unless their own handshake is in progress.

## Timing

- Reset values: all tvalid=0, all tready=0, dout_tdata=0, dout_tlast=0, status_tdata=0, blocks_done=0, busy=0, state IDLE. ctrl_tready rises the cycle after reset deasserts.
- Reset mid-block: return to IDLE on the next edge and drop any partial block with no DOUT or STATUS output. The upstream must also be reset.
- A ctrl handshake at cycle T gives din_tready=1 at T+1.
- The DIN beat completing a group at cycle L gives dout_tvalid=1 at L+1. din_tready is 0 throughout EMIT, with no overlap.
- The final DOUT handshake at D gives status_tvalid=1 at D+1. The STATUS handshake at S gives ctrl_tready=1 at S+1, and blocks_done updates at S+1.
- Valid outputs never drop without a handshake. Backpressure of any length holds data and tlast stable.
- Throughput: 9 cycles per 8 DIN beats, plus 2 cycles of per-block overhead.

## Structure

- Shared package ldpc_ber_tester_pkg: FSM state enum, control-field bit positions, status-field bit positions, beats-per-DOUT constant (8).
- One module, with no sub-module needed. The pack register is a plain register with a slot-indexed write.

## Test plan

- N=8, all LLRs 0x80 (negative), tlast on beat 8: one DOUT beat of all ones with tlast=1. Status = 0x0000_xx01 with the ID echoed and bit16=0. blocks_done=1.
- N=3, LLRs alternating 0x7F/0x80 per lane: one DOUT beat with bits [47:0]=0xAAAA_AAAA_AAAA, upper bits zero, tlast=1.
- N=20 with tlast only on beat 20: 3 DOUT beats; only the third has tlast=1; bits [127:64] of the third beat are zero.
- N=4 with tlast on beat 2 and not on beat 4: exactly 4 beats consumed, 1 DOUT beat, status bit16=1.
- dout_tready and status_tready held low for 50 cycles: tvalid and data remain stable, din_tready=0, no extra STATUS words.
- reset asserted mid-COLLECT (beat 5 of 8): next cycle is IDLE with all valids 0. A new block then completes normally, and blocks_done excludes the aborted block.
